// File: rtl/data_memory_p1.sv
// data_memory_p1: data-memory stage of the single-cycle core.
// Little-endian byte/halfword/word loads and stores into a Depth x 32-bit array.
// Faulting accesses (misaligned, out-of-range, illegal funct3, read+write together)
// are suppressed. The first fault since reset is latched into sticky status registers.
module data_memory_p1 #(
    parameter int Width = 32,
    parameter int Depth = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [Width-1:0] address,
    input  logic [Width-1:0] write_data,
    output logic [Width-1:0] read_data,
    output logic             fault,
    output logic             fault_sticky,
    output logic [Width-1:0] fault_addr,
    output logic [15:0]      store_count
);

    localparam int AddrBits = $clog2(Depth);
    localparam logic [Width-1:0] Limit = Width'(4 * Depth);

    logic [31:0]         mem [Depth];
    logic [AddrBits-1:0] word_idx;
    logic [1:0]          lane;
    logic [31:0]         word_rd;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic                is_half;
    logic                is_word;
    logic                misaligned;
    logic                out_of_range;
    logic                bad_load;
    logic                bad_store;
    logic                wr_en;
    logic [3:0]          byte_en;
    logic [31:0]         wr_word;

    assign word_idx = address[AddrBits+1:2];
    assign lane     = address[1:0];
    assign word_rd  = mem[word_idx];

    // Fault detection; only meaningful while an access is requested.
    always_comb begin
        is_half      = (funct3[1:0] == 2'b01);
        is_word      = (funct3[1:0] == 2'b10);
        misaligned   = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
        out_of_range = (address >= Limit);
        bad_load     = mem_read && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
        bad_store    = mem_write && (funct3[2] || (funct3 == 3'b011));
        fault        = (mem_read || mem_write) &&
                       (misaligned || out_of_range || bad_load || bad_store || (mem_read && mem_write));
    end

    // Load path: lane select plus sign/zero extension, zero when idle or faulting.
    always_comb begin
        rd_half   = address[1] ? word_rd[31:16] : word_rd[15:0];
        rd_byte   = word_rd[7:0];
        read_data = '0;
        case (lane)
            2'd0:    rd_byte = word_rd[7:0];
            2'd1:    rd_byte = word_rd[15:8];
            2'd2:    rd_byte = word_rd[23:16];
            default: rd_byte = word_rd[31:24];
        endcase
        if (mem_read && !fault) begin
            case (funct3)
                3'b000:  read_data = {{(Width-8){rd_byte[7]}}, rd_byte};
                3'b001:  read_data = {{(Width-16){rd_half[15]}}, rd_half};
                3'b010:  read_data = Width'(word_rd);
                3'b100:  read_data = {{(Width-8){1'b0}}, rd_byte};
                3'b101:  read_data = {{(Width-16){1'b0}}, rd_half};
                default: read_data = '0;
            endcase
        end
    end

    // Store lane enables and replicated write data; a store seen while reset is low is dropped.
    always_comb begin
        wr_en = mem_write && !fault && reset_n;
        case (funct3)
            3'b000: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{write_data[7:0]}};
            end
            3'b001: begin
                byte_en = address[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{write_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = write_data[31:0];
            end
        endcase
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // First-fault capture and committed-store counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_sticky <= 1'b0;
            fault_addr   <= '0;
            store_count  <= '0;
        end else begin
            if (fault && !fault_sticky) begin
                fault_sticky <= 1'b1;
                fault_addr   <= address;
            end
            if (wr_en) begin
                store_count <= store_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_p1.sv
// Testbench for data_memory_p1: expected load/fault results are queued at drive time
// and popped when the outputs are sampled on the falling edge.
module tb_data_memory_p1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        fault;
    logic        fault_sticky;
    logic [31:0] fault_addr;
    logic [15:0] store_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    data_memory_p1 #(.Width(32), .Depth(256)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .fault        (fault),
        .fault_sticky (fault_sticky),
        .fault_addr   (fault_addr),
        .store_count  (store_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one access just after a rising edge and check its combinational result at the falling edge.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        address    = a;
        write_data = wd;
        e.tag = tag;
        e.rd  = exp_rd;
        e.flt = exp_f;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            check_val({got.tag, "/rd"}, read_data, got.rd);
            check_val({got.tag, "/fault"}, {31'b0, fault}, {31'b0, got.flt});
        end
    endtask

    task automatic idle(input string tag);
        access(tag, 1'b0, 1'b0, F_W, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_sticky", {31'b0, fault_sticky}, 32'h0);
        check_val("rst_faddr", fault_addr, 32'h0);
        check_val("rst_count", {16'b0, store_count}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Extension on a word with sign bits in both halves.
        access("sw10",  0, 1, F_W,  32'h10, 32'h8000_00F1, 32'h0, 0);
        access("lb10",  1, 0, F_B,  32'h10, 32'h0, 32'hFFFF_FFF1, 0);
        access("lbu10", 1, 0, F_BU, 32'h10, 32'h0, 32'h0000_00F1, 0);
        access("lh10",  1, 0, F_H,  32'h10, 32'h0, 32'h0000_00F1, 0);
        access("lhu10", 1, 0, F_HU, 32'h10, 32'h0, 32'h0000_00F1, 0);
        access("lw10",  1, 0, F_W,  32'h10, 32'h0, 32'h8000_00F1, 0);
        access("lh12",  1, 0, F_H,  32'h12, 32'h0, 32'hFFFF_8000, 0);
        access("lhu12", 1, 0, F_HU, 32'h12, 32'h0, 32'h0000_8000, 0);
        access("lb13",  1, 0, F_B,  32'h13, 32'h0, 32'hFFFF_FF80, 0);

        // Partial stores merge into an existing word.
        access("sw20",  0, 1, F_W,  32'h20, 32'h1122_3344, 32'h0, 0);
        access("sb21",  0, 1, F_B,  32'h21, 32'hFFFF_FFAA, 32'h0, 0);
        access("sh22",  0, 1, F_H,  32'h22, 32'h1234_BEEF, 32'h0, 0);
        access("lw20",  1, 0, F_W,  32'h20, 32'h0, 32'hBEEF_AA44, 0);
        check_val("count4", {16'b0, store_count}, 32'd4);
        access("sw04",  0, 1, F_W,  32'h04, 32'hCAFE_F00D, 32'h0, 0);

        // First fault is captured; later ones are ignored and write nothing.
        check_val("sticky_pre", {31'b0, fault_sticky}, 32'h0);
        access("lw22",  1, 0, F_W,  32'h22, 32'h0, 32'h0, 1);
        idle("idle1");
        check_val("sticky_set", {31'b0, fault_sticky}, 32'h1);
        check_val("faddr22", fault_addr, 32'h22);
        access("sh05",  0, 1, F_H,  32'h05, 32'h0000_DEAD, 32'h0, 1);
        access("lw04",  1, 0, F_W,  32'h04, 32'h0, 32'hCAFE_F00D, 0);
        check_val("faddr_hold", fault_addr, 32'h22);
        check_val("count5", {16'b0, store_count}, 32'd5);

        // Range boundary, read+write together, illegal funct3 codes.
        access("sw400",  0, 1, F_W,    32'h400, 32'h5555_5555, 32'h0, 1);
        access("sb3ff",  0, 1, F_B,    32'h3FF, 32'h0000_005A, 32'h0, 0);
        access("lbu3ff", 1, 0, F_BU,   32'h3FF, 32'h0, 32'h0000_005A, 0);
        access("lbu400", 1, 0, F_BU,   32'h400, 32'h0, 32'h0, 1);
        access("rdwr0",  1, 1, F_W,    32'h0,   32'h0, 32'h0, 1);
        access("ld011",  1, 0, 3'b011, 32'h0,   32'h0, 32'h0, 1);
        access("ld110",  1, 0, 3'b110, 32'h0,   32'h0, 32'h0, 1);
        access("st100",  0, 1, 3'b100, 32'h10,  32'h0, 32'h0, 1);
        access("sw_al",  0, 1, F_W,    32'h12,  32'h0, 32'h0, 1);
        access("lw10b",  1, 0, F_W,    32'h10,  32'h0, 32'h8000_00F1, 0);
        idle("idle2");
        check_val("count6", {16'b0, store_count}, 32'd6);

        // Mid-cycle asynchronous reset with a store pending: status clears at once, store dropped.
        @(posedge clk);
        #1;
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        funct3     = F_W;
        address    = 32'h10;
        write_data = 32'h5555_5555;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_count", {16'b0, store_count}, 32'h0);
        check_val("arst_sticky", {31'b0, fault_sticky}, 32'h0);
        check_val("arst_faddr", fault_addr, 32'h0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b1;
        address   = 32'h22;
        #1;
        check_val("rst_comb_fault", {31'b0, fault}, 32'h1);
        check_val("rst_hold_sticky", {31'b0, fault_sticky}, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        access("sw30",   0, 1, F_W, 32'h30, 32'h0BAD_CAFE, 32'h0, 0);
        access("lw10r",  1, 0, F_W, 32'h10, 32'h0, 32'h8000_00F1, 0);
        access("lw30",   1, 0, F_W, 32'h30, 32'h0, 32'h0BAD_CAFE, 0);
        check_val("count_post", {16'b0, store_count}, 32'd1);

        // Counter wrap: 65535 more stores bring it back to zero.
        @(posedge clk);
        #1;
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        funct3     = F_W;
        address    = 32'h40;
        write_data = 32'h1234_5678;
        repeat (65535) @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        check_val("count_wrap", {16'b0, store_count}, 32'h0);
        access("lw40", 1, 0, F_W, 32'h40, 32'h0, 32'h1234_5678, 0);
        check_val("wrap_sticky", {31'b0, fault_sticky}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
